// File: rtl/add_sub_serial_unit.sv
// add_sub_serial_unit: chunk-serial add/subtract with saturation and status flags.
// Ports: clk, rst (async, active-high); in_valid/in_ready accept a, b, sub, signed_mode, sat_en;
// out_valid/out_ready hand off result plus carry_out, signed_overflow, unsigned_overflow,
// zero_flag, negative_flag, saturated; sticky_ovf accumulates overflows until clr_sticky.
module add_sub_serial_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             sat_en,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             signed_overflow,
  output logic             unsigned_overflow,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             saturated,
  output logic             sticky_ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] st;
  logic [WIDTH-1:0] a_r, b_r, raw, sat_val, fin;
  logic [IW-1:0] idx;
  logic [CHUNK:0] csum;
  logic c_r, sub_r, sm_r, se_r, last, co, uovf, sovf, ovf, sat;
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  // raw is the accumulated result with the current chunk merged in; only the
  // last RUN cycle's view of it is the complete raw sum used for the flags.
  always_comb begin
    csum = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_r};
    raw = result;
    raw[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    last = idx == IW'(NCHUNK - 1);
    co = csum[CHUNK];
    uovf = sub_r ? ~co : co;
    sovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (raw[WIDTH-1] != a_r[WIDTH-1]);
    ovf = sm_r ? sovf : uovf;
    sat = se_r && ovf;
    sat_val = sm_r ? {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}} : {WIDTH{~sub_r}};
    fin = sat ? sat_val : raw;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      sub_r <= 1'b0;
      sm_r <= 1'b0;
      se_r <= 1'b0;
      idx <= '0;
      result <= '0;
      carry_out <= 1'b0;
      signed_overflow <= 1'b0;
      unsigned_overflow <= 1'b0;
      zero_flag <= 1'b0;
      negative_flag <= 1'b0;
      saturated <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (st == IDLE && in_valid) begin
        a_r <= a;
        b_r <= sub ? ~b : b;
        c_r <= sub;
        sub_r <= sub;
        sm_r <= signed_mode;
        se_r <= sat_en;
        idx <= '0;
        st <= RUN;
      end else if (st == RUN) begin
        c_r <= co;
        idx <= idx + 1'b1;
        result <= last ? fin : raw;
        if (last) begin
          st <= DONE;
          carry_out <= co;
          signed_overflow <= sovf;
          unsigned_overflow <= uovf;
          zero_flag <= fin == '0;
          negative_flag <= fin[WIDTH-1];
          saturated <= sat;
        end
      end else if (st == DONE && out_ready) begin
        st <= IDLE;
      end
      // a completing overflow wins over a simultaneous clear
      sticky_ovf <= (st == RUN && last && ovf) || (sticky_ovf && !clr_sticky);
    end
  end
endmodule

// File: tb/tb_add_sub_serial_unit.sv
// tb_add_sub_serial_unit: table-driven scoreboard bench for add_sub_serial_unit (WIDTH=16, CHUNK=4).
module tb_add_sub_serial_unit;
  typedef struct {
    logic [15:0] a, b;
    logic sub, sm, se;
    logic [15:0] res;
    logic co, sovf, uovf, z, n, sat;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, sub = 1'b0, signed_mode = 1'b0;
  logic sat_en = 1'b0, clr_sticky = 1'b0, out_valid, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag, saturated, sticky_ovf;
  int total = 0, bad = 0;
  logic sticky_exp = 1'b0;
  vec_t tbl[11];
  vec_t q[$];
  add_sub_serial_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .signed_mode(signed_mode), .sat_en(sat_en), .clr_sticky(clr_sticky), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out), .signed_overflow(signed_overflow),
    .unsigned_overflow(unsigned_overflow), .zero_flag(zero_flag), .negative_flag(negative_flag),
    .saturated(saturated), .sticky_ovf(sticky_ovf)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [15:0] va, logic [15:0] vb, logic vsub, logic vsm, logic vse,
                              logic [15:0] vres, logic vco, logic vsovf, logic vuovf, logic vz,
                              logic vn, logic vsat);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vsub; v.sm = vsm; v.se = vse; v.res = vres;
    v.co = vco; v.sovf = vsovf; v.uovf = vuovf; v.z = vz; v.n = vn; v.sat = vsat;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic do_op(input vec_t v, input int hold, input logic clr_hold);
    vec_t e;
    int n;
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    sticky_exp = 1'b0;
    chk("sticky_clr", sticky_ovf, sticky_exp);
    chk("in_ready_idle", in_ready, 1);
    a = v.a; b = v.b; sub = v.sub; signed_mode = v.sm; sat_en = v.se;
    in_valid = 1'b1; clr_sticky = clr_hold;
    @(negedge clk);
    in_valid = 1'b0;
    q.push_back(v);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    clr_sticky = 1'b0;
    chk("latency", n, 4);
    e = q.pop_front();
    if (e.se ? 1'b0 : 1'b0) sticky_exp = 1'b1;
    if (e.sm ? e.sovf : e.uovf) sticky_exp = 1'b1;
    chk("result", result, e.res);
    chk("carry_out", carry_out, e.co);
    chk("signed_ovf", signed_overflow, e.sovf);
    chk("unsigned_ovf", unsigned_overflow, e.uovf);
    chk("zero", zero_flag, e.z);
    chk("negative", negative_flag, e.n);
    chk("saturated", saturated, e.sat);
    chk("sticky", sticky_ovf, sticky_exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = ~v.a; sub = ~v.sub;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", result, e.res);
      chk("hold_flags", {carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag, saturated},
          {e.co, e.sovf, e.uovf, e.z, e.n, e.sat});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
  endtask
  initial begin
    tbl[0]  = mk(16'h7FFF, 16'h0001, 0, 1, 0, 16'h8000, 0, 1, 0, 0, 1, 0);
    tbl[1]  = mk(16'h0000, 16'h0001, 1, 0, 1, 16'h0000, 0, 0, 1, 1, 0, 1);
    tbl[2]  = mk(16'h0000, 16'h0001, 1, 0, 0, 16'hFFFF, 0, 0, 1, 0, 1, 0);
    tbl[3]  = mk(16'h8000, 16'h0001, 1, 1, 1, 16'h8000, 1, 1, 0, 0, 1, 1);
    tbl[4]  = mk(16'h1234, 16'h1111, 0, 0, 0, 16'h2345, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(16'hFFFF, 16'h0001, 0, 0, 1, 16'hFFFF, 1, 0, 1, 0, 1, 1);
    tbl[6]  = mk(16'hFFFF, 16'h0001, 0, 1, 1, 16'h0000, 1, 0, 1, 1, 0, 0);
    tbl[7]  = mk(16'h7000, 16'h7000, 0, 1, 1, 16'h7FFF, 0, 1, 0, 0, 0, 1);
    tbl[8]  = mk(16'h5555, 16'h5555, 1, 0, 1, 16'h0000, 1, 0, 0, 1, 0, 0);
    tbl[9]  = mk(16'h0003, 16'h0005, 1, 1, 1, 16'hFFFE, 0, 0, 1, 0, 1, 0);
    tbl[10] = mk(16'h00FF, 16'h0F01, 0, 0, 0, 16'h1000, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sticky", sticky_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) do_op(tbl[i], 0, 1'b0);
    do_op(tbl[4], 3, 1'b0);
    do_op(tbl[3], 0, 1'b1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clr_alone", sticky_ovf, 0);
    do_op(tbl[5], 0, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; signed_mode = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag, saturated, sticky_ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    chk("abort_in_ready", in_ready, 1);
    do_op(tbl[4], 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_sub_serial_unit.md
ADD_SUB_SERIAL_UNIT -- requirements
Module: add_sub_serial_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  unit can accept an operation.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 sub  input  1  0 = a+b, 1 = a-b.
REQ-009 signed_mode  input  1  1 = two's-complement saturation rules, 0 = unsigned.
REQ-010 sat_en  input  1  1 = clamp result on overflow of the selected mode.
REQ-011 clr_sticky  input  1  clears sticky_ovf.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  WIDTH  final (possibly saturated) result.
REQ-015 carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag, saturated  output  1 each  status flags.
REQ-016 sticky_ovf  output  1  set by any completed op whose selected-mode overflow flag is 1.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-018 IDLE: on in_valid=1 at an edge, SHALL capture a, sub ? ~b : b, sub as initial carry, signed_mode, sat_en; clear chunk index; go to RUN.
REQ-019 RUN: each cycle SHALL add chunk k of captured operands plus stored carry, write sum into result bits [k*CHUNK +: CHUNK], register chunk carry-out; after chunk NCHUNK-1 go to DONE.
REQ-020 Latency SHALL be exactly NCHUNK cycles: out_valid rises at the NCHUNK-th edge after the accepting edge.
REQ-021 carry_out SHALL equal final MSB-chunk carry; unsigned_overflow = sub ? ~carry_out : carry_out.
REQ-022 signed_overflow SHALL be 1 when a[MSB] equals effective-b[MSB] and raw result[MSB] differs.
REQ-023 With sat_en=1 and selected-mode overflow, result SHALL clamp: signed, a[MSB]=0 -> 0x7F..F, a[MSB]=1 -> 0x80..0; unsigned add -> all ones, unsigned sub -> all zeros; saturated = 1, else 0.
REQ-024 zero_flag and negative_flag SHALL be computed on the final (post-saturation) result; carry_out and overflow flags on the raw sum.
REQ-025 DONE: result and all flags SHALL stay stable while out_ready=0; on out_ready=1 at an edge go to IDLE (in_ready=1 next cycle).
REQ-026 in_valid, operands and mode inputs SHALL be ignored outside IDLE.
REQ-027 sticky_ovf SHALL set on the edge entering DONE if the selected-mode overflow is 1; clr_sticky=1 clears it; simultaneous set and clear SHALL leave it 1.
REQ-028 Partial results SHALL not be visible as valid: result may change during RUN but out_valid=0.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, out_valid=0, result=0, all flags=0, sticky_ovf=0, chunk index 0, regardless of clk.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; in_ready=1 once rst deasserts.
REQ-031 First accept after reset release SHALL occur no earlier than the first rising edge with rst=0.

Verification (WIDTH=16, CHUNK=4)
REQ-032 add 0x7FFF+0x0001, sat_en=0 -> after 4 cycles result 0x8000, signed_overflow 1, unsigned_overflow 0, carry_out 0, negative_flag 1.
REQ-033 sub 0x0000-0x0001 unsigned, sat_en=1 -> result 0x0000, carry_out 0, unsigned_overflow 1, saturated 1, zero_flag 1; same with sat_en=0 -> 0xFFFF.
REQ-034 sub 0x8000-0x0001 signed, sat_en=1 -> raw 0x7FFF, carry_out 1, signed_overflow 1, result 0x8000, saturated 1, sticky_ovf 1.
REQ-035 out_ready held 0 for 3 cycles in DONE -> result/flags unchanged, in_ready 0, new in_valid ignored; out_ready=1 -> in_ready 1 next cycle.
REQ-036 rst pulsed during cycle 2 of RUN -> out_valid, result, flags 0 immediately, no out_valid afterwards; next op 0x1234+0x1111 -> 0x2345.
REQ-037 clr_sticky=1 on same edge as overflowing completion -> sticky_ovf 1; clr_sticky alone next cycle -> 0.
